// File: rtl/pc_pkg.sv
// Shared types for the PC sequencer: FSM state and redirect-select encoding.
package pc_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt
  } pc_state_e;

  // Next-PC source chosen in RUN, listed from lowest to highest precedence.
  typedef enum logic [2:0] {
    SelInc,
    SelHold,
    SelRet,
    SelJump,
    SelBranch
  } redir_sel_e;

  // True for sources that load an external target (and so can be misaligned).
  function automatic logic is_redirect(redir_sel_e sel);
    return (sel == SelBranch) || (sel == SelJump) || (sel == SelRet);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push to a full stack overwrites the oldest
// entry; a pop of an empty stack is ignored.
module ras_stack #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic [PtrW-1:0] top_idx;

  // The write pointer wraps naturally because DEPTH is a power of two.
  assign top_idx = wr_ptr_q - 1'b1;
  assign top     = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(DEPTH));

  // Pointer and occupancy tracking; push+pop replaces the top in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (push && !pop) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (!full) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (pop && !push && !empty) begin
      wr_ptr_q <= wr_ptr_q - 1'b1;
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  // Entry storage; contents are meaningless while the count says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[pop ? top_idx : wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT -> RUN -> HALT FSM with prioritised redirects
// (branch > jump > ret > stall > increment) and misaligned-target rejection.
// Optional return-address stack is compiled in with the PC_RAS_EN macro.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            call,
  input  logic            ret,
  input  logic [XLEN-1:0] ret_target,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misalign_err
);

  pc_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            misalign_q;

  redir_sel_e      sel;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] ret_addr;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            run_ok;

  // Increment wraps modulo 2^XLEN by truncation.
  assign pc_inc = pc_q + XLEN'(INC);
  assign run_ok = (state_q == StRun) && !halt;

  // Pick the next-PC source by fixed priority; redirects override stall.
  always_comb begin
    sel = SelInc;
    if (branch_taken) begin
      sel = SelBranch;
    end else if (jump) begin
      sel = SelJump;
    end else if (ret) begin
      sel = SelRet;
    end else if (stall) begin
      sel = SelHold;
    end
  end

  // Candidate next PC for the chosen source.
  always_comb begin
    next_pc = pc_q;
    unique case (sel)
      SelBranch: next_pc = branch_target;
      SelJump:   next_pc = jump_target;
      SelRet:    next_pc = ret_addr;
      SelInc:    next_pc = pc_inc;
      default:   next_pc = pc_q;
    endcase
  end

  assign misaligned = is_redirect(sel) && (next_pc[1:0] != 2'b00);

`ifdef PC_RAS_EN
  logic            ras_push;
  logic            ras_pop;
  logic            ras_empty;
  logic            unused_ras_full;
  logic [XLEN-1:0] ras_top;

  // Stack side effects happen only for a redirect that actually loads.
  assign ras_push = run_ok && (sel == SelJump) && call && !misaligned;
  assign ras_pop  = run_ok && (sel == SelRet) && !ras_empty && !misaligned;
  assign ret_addr = ras_empty ? ret_target : ras_top;

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (unused_ras_full)
  );
`else
  logic unused_call;

  assign unused_call = call;
  assign ret_addr    = ret_target;
`endif

  // Sequencer FSM with registered PC, valid and misalign pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      unique case (state_q)
        StBoot: begin
          state_q    <= StRun;
          pc_q       <= RESET_VECTOR;
          pc_valid_q <= 1'b1;
        end
        StRun: begin
          if (halt) begin
            // Halt wins; any simultaneous redirect is dropped.
            state_q    <= StHalt;
            pc_valid_q <= 1'b0;
          end else if (misaligned) begin
            misalign_q <= 1'b1;
          end else begin
            pc_q <= next_pc;
          end
        end
        StHalt: begin
          if (resume && !halt) begin
            state_q    <= StRun;
            pc_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= StBoot;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_out       = pc_q;
  assign pc_valid     = pc_valid_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the stimulus process pushes the expected
// outputs for each clock edge; the monitor pops and compares on the falling edge.
module tb_pc_sequencer;

  localparam int unsigned XLEN = 32;
`ifdef PC_RAS_EN
  localparam bit HasRas = 1'b1;
`else
  localparam bit HasRas = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stall, halt, resume, branch_taken, jump, call, ret;
  logic [XLEN-1:0] branch_target, jump_target, ret_target;
  logic [XLEN-1:0] pc_out;
  logic            pc_valid, misalign_err;

  typedef struct {
    string           name;
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            mis;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  pc_sequencer #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0),
    .INC          (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .halt          (halt),
    .resume        (resume),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .call          (call),
    .ret           (ret),
    .ret_target    (ret_target),
    .pc_out        (pc_out),
    .pc_valid      (pc_valid),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic idle();
    stall = 0; halt = 0; resume = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
    branch_target = '0; jump_target = '0; ret_target = '0;
  endtask

  // Apply the currently driven inputs across one rising edge and queue the
  // outputs expected after it.
  task automatic step(input string name, input logic v, input logic [XLEN-1:0] pc, input logic m);
    exp_t e;
    @(posedge clk);
    e.name = name; e.valid = v; e.pc = pc; e.mis = m;
    exp_q.push_back(e);
    #1 idle();
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".valid"}, XLEN'(pc_valid), XLEN'(e.valid));
      check({e.name, ".pc"}, pc_out, e.pc);
      check({e.name, ".mis"}, XLEN'(misalign_err), XLEN'(e.mis));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst.pc", pc_out, 32'h0);
    check("rst.valid", XLEN'(pc_valid), 32'h0);
    check("rst.mis", XLEN'(misalign_err), 32'h0);

    @(negedge clk) rst_n = 1'b1;
    #1 check("boot.valid", XLEN'(pc_valid), 32'h0);
    step("boot_exit", 1, 32'h0, 0);
    step("inc4", 1, 32'h4, 0);
    step("inc8", 1, 32'h8, 0);
    step("incC", 1, 32'hC, 0);
    step("inc10", 1, 32'h10, 0);

    // Branch beats jump and stall.
    branch_taken = 1; branch_target = 32'h100; jump = 1; jump_target = 32'h200; stall = 1;
    step("prio_branch", 1, 32'h100, 0);
    branch_taken = 1; branch_target = 32'h10;
    step("back_to_10", 1, 32'h10, 0);
    branch_taken = 1; branch_target = 32'h102; jump = 1; jump_target = 32'h200; stall = 1;
    step("mis_branch", 1, 32'h10, 1);
    step("mis_pulse_end", 1, 32'h14, 0);
    stall = 1;
    step("stall_hold", 1, 32'h14, 0);
    jump = 1; jump_target = 32'h201;
    step("mis_jump", 1, 32'h14, 1);
    jump = 1; jump_target = 32'h200;
    step("jump_ok", 1, 32'h200, 0);
    ret = 1; ret_target = 32'h3;
    step("mis_ret", 1, 32'h200, 1);

    // Increment wrap.
    branch_taken = 1; branch_target = 32'hFFFF_FFFC;
    step("to_top", 1, 32'hFFFF_FFFC, 0);
    step("wrap", 1, 32'h0, 0);
    step("after_wrap", 1, 32'h4, 0);

    // Five calls into a four-deep stack, then five returns.
    branch_taken = 1; branch_target = 32'h0;
    step("to_0", 1, 32'h0, 0);
    jump = 1; call = 1; jump_target = 32'h10; step("call0", 1, 32'h10, 0);
    jump = 1; call = 1; jump_target = 32'h20; step("call1", 1, 32'h20, 0);
    jump = 1; call = 1; jump_target = 32'h30; step("call2", 1, 32'h30, 0);
    jump = 1; call = 1; jump_target = 32'h40; step("call3", 1, 32'h40, 0);
    jump = 1; call = 1; jump_target = 32'h100; step("call4", 1, 32'h100, 0);
    ret = 1; ret_target = 32'h80; step("ret0", 1, HasRas ? 32'h44 : 32'h80, 0);
    ret = 1; ret_target = 32'h80; step("ret1", 1, HasRas ? 32'h34 : 32'h80, 0);
    ret = 1; ret_target = 32'h80; step("ret2", 1, HasRas ? 32'h24 : 32'h80, 0);
    ret = 1; ret_target = 32'h80; step("ret3", 1, HasRas ? 32'h14 : 32'h80, 0);
    ret = 1; ret_target = 32'h80; step("ret_empty", 1, 32'h80, 0);

    // Call together with ret: only the jump/call applies.
    jump = 1; call = 1; jump_target = 32'h50; ret = 1; ret_target = 32'h90;
    step("call_ret", 1, 32'h50, 0);
    ret = 1; ret_target = 32'h90;
    step("ret_after_cr", 1, HasRas ? 32'h84 : 32'h90, 0);

    // Call without jump pushes nothing.
    branch_taken = 1; branch_target = 32'h20;
    step("to_20a", 1, 32'h20, 0);
    call = 1;
    step("call_alone", 1, 32'h24, 0);
    ret = 1; ret_target = 32'hA0;
    step("ret_no_push", 1, 32'hA0, 0);

    // Halt beats a simultaneous jump; HALT ignores redirects.
    branch_taken = 1; branch_target = 32'h20;
    step("to_20b", 1, 32'h20, 0);
    halt = 1; jump = 1; jump_target = 32'h300;
    step("halt", 0, 32'h20, 0);
    jump = 1; jump_target = 32'h300; stall = 1; branch_taken = 1; branch_target = 32'h400;
    step("halt_ignore", 0, 32'h20, 0);
    halt = 1; resume = 1;
    step("halt_resume", 0, 32'h20, 0);
    resume = 1;
    step("resume", 1, 32'h20, 0);
    step("resume_inc", 1, 32'h24, 0);

    // Reset mid-HALT with a stacked return address.
    jump = 1; call = 1; jump_target = 32'h60;
    step("call_60", 1, 32'h60, 0);
    halt = 1;
    step("halt2", 0, 32'h60, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.pc", pc_out, 32'h0);
    check("async_rst.valid", XLEN'(pc_valid), 32'h0);
    check("async_rst.mis", XLEN'(misalign_err), 32'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step("reboot", 1, 32'h0, 0);
    ret = 1; ret_target = 32'h70;
    step("ret_after_rst", 1, 32'h70, 0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, PC and target width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 Parameter INC, default 4, sequential PC increment.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, at least 2).
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 stall  in  1  hold the PC (pipeline back-pressure).
REQ-009 halt  in  1  request entry to HALT.
REQ-010 resume  in  1  request exit from HALT.
REQ-011 branch_taken  in  1  branch redirect strobe.
REQ-012 branch_target  in  XLEN  branch destination.
REQ-013 jump  in  1  jump redirect strobe.
REQ-014 jump_target  in  XLEN  jump destination.
REQ-015 call  in  1  qualifies the jump as a call (push the return address).
REQ-016 ret  in  1  return redirect strobe.
REQ-017 ret_target  in  XLEN  fallback return destination.
REQ-018 pc_out  out  XLEN  registered current PC.
REQ-019 pc_valid  out  1  pc_out is a fetchable address.
REQ-020 misalign_err  out  1  one-cycle pulse when a rejected target has bits [1:0] not equal to 0.

Function
REQ-021 FSM states SHALL be BOOT, RUN and HALT; reset enters BOOT.
REQ-022 BOOT SHALL last exactly one cycle with pc_valid=0, then move to RUN with pc_out=RESET_VECTOR and pc_valid=1.
REQ-023 In RUN, each cycle SHALL update pc_out using priority branch_taken > jump > ret > stall-hold > pc_out+INC.
REQ-024 A redirect SHALL override stall in the same cycle, as a flush.
REQ-025 A redirect target with bits [1:0] not equal to 0 SHALL NOT load: pc_out holds and misalign_err=1 for that cycle.
REQ-026 pc_out+INC SHALL wrap modulo 2^XLEN with no error.
REQ-027 halt in RUN SHALL move to HALT next cycle with pc_out held and pc_valid=0; halt takes priority over a simultaneous redirect, and that redirect is dropped.
REQ-028 In HALT, redirects and stall SHALL be ignored; resume SHALL return to RUN next cycle with pc_out unchanged and pc_valid=1.
REQ-029 halt and resume both high in HALT SHALL keep HALT.
REQ-030 jump with call SHALL push pc_out+INC when PC_RAS_EN is defined; call without jump SHALL be ignored.

Reset
REQ-031 Asserting rst_n=0 SHALL force immediately, mid-operation included: pc_out=RESET_VECTOR, pc_valid=0, misalign_err=0, state=BOOT, RAS empty.
REQ-032 Deassertion SHALL take effect on the first rising clk edge after rst_n returns high.

Configuration
REQ-033 Macro PC_RAS_EN SHALL compile in a RAS_DEPTH-entry return-address stack.
REQ-034 With PC_RAS_EN defined, ret SHALL pop and use the top entry; on an empty stack it SHALL use ret_target.
REQ-035 With PC_RAS_EN defined, a push to a full stack SHALL overwrite the oldest entry (circular).
REQ-036 With PC_RAS_EN defined, a simultaneous call and ret SHALL apply only the higher-priority jump/call.
REQ-037 Without PC_RAS_EN, ret SHALL always use ret_target, call SHALL be ignored, and no stack storage SHALL exist.

Structure
REQ-038 A shared package pc_pkg SHALL hold the FSM state enum (BOOT/RUN/HALT) and the redirect-select encoding.
REQ-039 The stack SHALL be a sub-module ras_stack (push, pop, top, empty, full), instantiated only under PC_RAS_EN.

Verification
REQ-040 Release rst_n -> one cycle pc_valid=0, then pc_out=0x0, 0x4, 0x8 with pc_valid=1.
REQ-041 RUN at 0x10: branch_taken=1, branch_target=0x100, jump=1, jump_target=0x200, stall=1 -> next pc_out=0x100; branch_target=0x102 instead -> pc_out stays 0x10 and misalign_err pulses.
REQ-042 pc_out=0xFFFFFFFC, no redirect -> next pc_out=0x00000000.
REQ-043 PC_RAS_EN, RAS_DEPTH=4, five calls from 0x0, 0x10, 0x20, 0x30, 0x40 -> four rets return 0x44, 0x34, 0x24, 0x14; fifth ret uses ret_target=0x80.
REQ-044 halt at pc_out=0x20 with a simultaneous jump to 0x300 -> pc_out holds 0x20 with pc_valid=0; resume -> pc_valid=1 at 0x20, then 0x24.
REQ-045 rst_n=0 mid-HALT with a non-empty RAS -> pc_out=RESET_VECTOR at once; after release, a ret uses ret_target.
